// File: rtl/event_encoder8to3.sv
// Event encoder: captures up to eight event lines into a pending register and
// issues one 3-bit index per accepted valid/ready transfer.

module event_encoder8to3_lane #(
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ev,
  input  logic load,
  output logic pend,
  output logic hit
);
  logic prev;
  logic set;

  assign set = EDGE_DETECT ? (ev & ~prev) : ev;
  // A new occurrence on a bit that is still pending and not leaving this edge is lost.
  assign hit = set & pend & ~load;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= ev;
      pend <= set | (pend & ~load);
    end
  end
endmodule

module event_encoder8to3 #(
  parameter bit EDGE_DETECT   = 1'b1,
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] event_in,
  input  logic       out_ready,
  input  logic       clear_overflow,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic [7:0] pending,
  output logic       overflow
);
  logic [7:0] load;
  logic [7:0] hit;
  logic [2:0] sel;
  logic [2:0] rr_ptr;
  logic       take;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    event_encoder8to3_lane #(.EDGE_DETECT(EDGE_DETECT)) u_lane (
      .clock  (clock),
      .reset_n(reset_n),
      .ev     (event_in[i]),
      .load   (load[i]),
      .pend   (pending[i]),
      .hit    (hit[i])
    );
  end

  // Selection looks only at the registered pending vector.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    if (!PRIORITY_MODE) begin
      for (int i = 0; i < 8; i++)
        if (pending[i]) sel = 3'(i);
    end else begin
      for (int off = 1; off <= 8; off++) begin
        idx = rr_ptr + 3'(off);
        if (!found && pending[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign take = (~out_valid | out_ready) & (|pending);
  assign load = take ? (8'(1) << sel) : 8'h00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      rr_ptr    <= 3'd7;
      overflow  <= 1'b0;
    end else begin
      if (~out_valid | out_ready) out_valid <= |pending;
      if (take) begin
        out_code <= sel;
        rr_ptr   <= sel;
      end
      // Set beats clear when both land in the same cycle.
      if (|hit)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_event_encoder8to3.sv
// Bench for event_encoder8to3: three parameter variants share one stimulus and
// are compared each cycle against a behavioural model, plus directed checks.

module tb_event_encoder8to3;
  localparam int N = 3;  // 0: edge/fixed, 1: level/round-robin, 2: level/fixed

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] event_in;
  logic       out_ready;
  logic       clear_overflow;
  logic [N-1:0]      vld;
  logic [N-1:0][2:0] code;
  logic [N-1:0][7:0] pnd;
  logic [N-1:0]      ovf;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    event_encoder8to3 #(
      .EDGE_DETECT  (g == 0),
      .PRIORITY_MODE(g == 1)
    ) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .event_in      (event_in),
      .out_ready     (out_ready),
      .clear_overflow(clear_overflow),
      .out_valid     (vld[g]),
      .out_code      (code[g]),
      .pending       (pnd[g]),
      .overflow      (ovf[g])
    );
  end

  // Reference model state
  bit   m_ed[N] = '{1'b1, 1'b0, 1'b0};
  bit   m_rr[N] = '{1'b0, 1'b1, 1'b0};
  bit   m_pend[N][8];
  bit   m_prev[N][8];
  bit   m_v[N];
  int   m_code[N];
  int   m_last[N];
  bit   m_ovf[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < N; g++) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[g][i] = 0;
        m_prev[g][i] = 0;
      end
      m_v[g] = 0; m_code[g] = 0; m_last[g] = 7; m_ovf[g] = 0;
    end
  endtask

  task automatic model_step();
    for (int g = 0; g < N; g++) begin
      bit set[8];
      bit any;
      int k;
      any = 0;
      k = -1;
      for (int i = 0; i < 8; i++) begin
        set[i] = event_in[i] && !(m_ed[g] && m_prev[g][i]);
        any |= m_pend[g][i];
      end
      if ((!m_v[g] || out_ready) && any) begin
        if (!m_rr[g]) begin
          for (int i = 7; i >= 0 && k < 0; i--) if (m_pend[g][i]) k = i;
        end else begin
          for (int s = 1; s <= 8 && k < 0; s++)
            if (m_pend[g][(m_last[g] + s) % 8]) k = (m_last[g] + s) % 8;
        end
      end
      if (clear_overflow) m_ovf[g] = 0;
      for (int i = 0; i < 8; i++)
        if (set[i] && m_pend[g][i] && i != k) m_ovf[g] = 1;
      for (int i = 0; i < 8; i++) begin
        m_pend[g][i] = set[i] || (m_pend[g][i] && i != k);
        m_prev[g][i] = event_in[i];
      end
      if (!m_v[g] || out_ready) m_v[g] = (k >= 0);
      if (k >= 0) begin
        m_code[g] = k;
        m_last[g] = k;
      end
    end
  endtask

  function automatic logic [7:0] mpend(int g);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_pend[g][i];
    return p;
  endfunction

  task automatic check_all();
    for (int g = 0; g < N; g++) begin
      chk($sformatf("d%0d_valid", g), 32'(vld[g]), 32'(m_v[g]));
      chk($sformatf("d%0d_code", g), 32'(code[g]), 32'(m_code[g]));
      chk($sformatf("d%0d_pending", g), 32'(pnd[g]), 32'(mpend(g)));
      chk($sformatf("d%0d_overflow", g), 32'(ovf[g]), 32'(m_ovf[g]));
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(input logic [7:0] ev, input logic rdy, input logic clr);
    event_in = ev; out_ready = rdy; clear_overflow = clr;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int g = 0; g < N; g++) begin
      chk("rst_valid", 32'(vld[g]), 0);
      chk("rst_pending", 32'(pnd[g]), 0);
      chk("rst_overflow", 32'(ovf[g]), 0);
    end
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    #2;
    model_reset();
    check_all();
    chk("rst_code", 32'(code[0]), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // single event, two-edge latency
    drive(8'h04, 1, 0); cycle();
    chk("t1_pend", 32'(pnd[0]), 32'h04); chk("t1_v0", 32'(vld[0]), 0);
    drive(8'h00, 1, 0); cycle();
    chk("t1_v1", 32'(vld[0]), 1); chk("t1_code", 32'(code[0]), 2); chk("t1_pend0", 32'(pnd[0]), 0);
    cycle();
    chk("t1_drop", 32'(vld[0]), 0); chk("t1_hold", 32'(code[0]), 2);

    // fixed priority burst
    drive(8'hA1, 1, 0); cycle();
    chk("t2_pend", 32'(pnd[0]), 32'hA1);
    drive(8'h00, 1, 0);
    cycle(); chk("t2_c7", 32'(code[0]), 7); chk("t2_v", 32'(vld[0]), 1);
    cycle(); chk("t2_c5", 32'(code[0]), 5); chk("t2_v", 32'(vld[0]), 1);
    cycle(); chk("t2_c0", 32'(code[0]), 0); chk("t2_v", 32'(vld[0]), 1);
    cycle(); chk("t2_drop", 32'(vld[0]), 0);

    // backpressure
    drive(8'h0C, 0, 0); cycle();
    drive(8'h00, 0, 0); cycle();
    chk("t3_c3", 32'(code[0]), 3); chk("t3_pend", 32'(pnd[0]), 32'h04);
    cycle();
    chk("t3_hold", 32'(code[0]), 3); chk("t3_v", 32'(vld[0]), 1);
    drive(8'h00, 1, 0); cycle();
    chk("t3_c2", 32'(code[0]), 2); chk("t3_pend0", 32'(pnd[0]), 0);
    cycle(); chk("t3_drop", 32'(vld[0]), 0);

    // overflow and clear
    drive(8'h10, 0, 0); cycle();
    drive(8'h00, 0, 0); cycle();
    chk("t4_c4", 32'(code[0]), 4);
    drive(8'h10, 0, 0); cycle();
    chk("t4_noovf", 32'(ovf[0]), 0);
    drive(8'h00, 0, 0); cycle();
    drive(8'h10, 0, 0); cycle();
    chk("t4_ovf", 32'(ovf[0]), 1);
    drive(8'h00, 0, 1); cycle();
    chk("t4_clr", 32'(ovf[0]), 0);
    drive(8'h10, 0, 1); cycle();
    chk("t4_setwins", 32'(ovf[0]), 1);
    drive(8'h00, 0, 1); cycle();
    drive(8'h00, 1, 0); cycle(); cycle(); cycle();

    // randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      drive(8'($urandom & $urandom & $urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      cycle();
      if ($urandom_range(0, 63) == 0) do_reset();
    end

    // round-robin vs fixed with a level-held pair
    drive(8'h00, 1, 0);
    do_reset();
    drive(8'h81, 1, 0); cycle();
    chk("t5_v0", 32'(vld[1]), 0);
    for (int n = 0; n < 8; n++) begin
      cycle();
      chk("t5_rr", 32'(code[1]), (n % 2 == 0) ? 0 : 7);
      chk("t5_rrv", 32'(vld[1]), 1);
      chk("t5_fix", 32'(code[2]), 7);
    end

    // reset while a transfer is outstanding
    drive(8'h00, 1, 0); cycle(); cycle(); cycle();
    drive(8'h08, 0, 0); cycle();
    drive(8'hF0, 0, 0); cycle();
    chk("t6_v", 32'(vld[0]), 1); chk("t6_pend", 32'(pnd[0]), 32'hF0); chk("t6_c3", 32'(code[0]), 3);
    do_reset();
    chk("t6_rst_v", 32'(vld[0]), 0); chk("t6_rst_p", 32'(pnd[0]), 0);
    cycle();
    chk("t6_recap", 32'(pnd[0]), 32'hF0); chk("t6_v0", 32'(vld[0]), 0);
    cycle();
    chk("t6_first", 32'(code[0]), 7); chk("t6_v1", 32'(vld[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
